// File: rtl/mac_acc_pipe.sv
// ============================================================================
// mac_acc_pipe
// ----------------------------------------------------------------------------
// Pipelined neuron multiply-accumulate with bias, optional ReLU and output
// saturation. A neuron arrives as BEATS beats of LANES pixel/weight pairs.
// All products of all beats are summed, the bias is added, and one OUTW-bit
// result is produced per neuron. Both sides use valid/ready handshakes.
//
// Pipeline (beat accepted at edge k):
//   S1 @k   : LANES products plus first/last/mode/relu tags and bias
//   S2 @k+1 : adder-tree sum of the S1 products
//   S3 @k+2 : accumulator update; on the last beat the saturated result is
//             loaded into dout and out_valid is raised
// A held output (out_valid & ~out_ready) freezes every stage.
//
// Ports
//   clk          in   1          clock, rising edge
//   rst_n        in   1          asynchronous active-low reset
//   clear        in   1          synchronous abort: drop partial neuron, flush
//   mode_signed  in   1          1 = two's-complement p/w/bias (first beat)
//   relu_en      in   1          1 = negative totals become 0 (first beat)
//   in_valid     in   1          p/w/bias valid
//   in_ready     out  1          beat accepted when in_valid & in_ready
//   p            in   LANES*DW   pixels, lane i = p[i*DW +: DW]
//   w            in   LANES*DW   weights, same packing
//   bias         in   BW         bias, sampled on the first beat only
//   out_valid    out  1          dout/out_sat valid
//   out_ready    in   1          result consumed when out_valid & out_ready
//   dout         out  OUTW       final result
//   out_sat      out  1          1 = dout was clamped
// ============================================================================
module mac_acc_pipe #(
    parameter int LANES = 16,
    parameter int DW    = 8,
    parameter int BW    = 8,
    parameter int BEATS = 4,
    parameter int OUTW  = 22
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  mode_signed,
    input  logic                  relu_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   p,
    input  logic [LANES*DW-1:0]   w,
    input  logic [BW-1:0]         bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUTW-1:0]       dout,
    output logic                  out_sat
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    localparam int PW   = 2 * DW;                                // product
    localparam int SW   = PW + $clog2(LANES);                    // tree sum
    localparam int ACCW = PW + $clog2(LANES * BEATS) + 2;        // accumulator
    localparam int CW   = (BEATS > 1) ? $clog2(BEATS) : 1;       // beat counter
    // Saturation is evaluated one bit wider than both ACCW and OUTW so the
    // clamp limits are always representable as signed constants.
    localparam int EW   = ((ACCW > OUTW) ? ACCW : OUTW) + 1;

    localparam logic [EW-1:0]        ONE  = EW'(1);
    localparam logic signed [EW-1:0] UMAX = $signed((ONE << OUTW) - ONE);
    localparam logic signed [EW-1:0] SMAX = $signed((ONE << (OUTW - 1)) - ONE);
    localparam logic signed [EW-1:0] SMIN = -$signed(ONE << (OUTW - 1));

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic stall;
    logic accept;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall & ~clear;
    assign accept   = in_valid & in_ready;

    // ------------------------------------------------------------------------
    // Beat FSM
    // ------------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           beat_first;
    logic           beat_last;

    assign beat_first = (state_q == IDLE);
    assign beat_last  = (cnt_q == CW'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values present before the edge.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets its default first, so no path through
        // the block leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            if (beat_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                state_d = ACC;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-neuron settings: taken from the ports on the first beat and held
    // for the remaining beats of the same neuron.
    // ------------------------------------------------------------------------
    logic           cur_signed;
    logic           cur_relu;
    logic [BW-1:0]  cur_bias;
    logic           eff_signed;
    logic           eff_relu;
    logic [BW-1:0]  eff_bias;

    assign eff_signed = beat_first ? mode_signed : cur_signed;
    assign eff_relu   = beat_first ? relu_en     : cur_relu;
    assign eff_bias   = beat_first ? bias        : cur_bias;

    // ------------------------------------------------------------------------
    // Lane multipliers. Operands are extended to PW bits according to the
    // mode; the low PW bits of the product are then correct for both signed
    // and unsigned interpretation.
    // ------------------------------------------------------------------------
    logic [PW-1:0] prod_in [LANES];

    always_comb begin
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        ea      = '0;
        eb      = '0;
        prod_in = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            if (eff_signed) begin
                ea = PW'($signed(p[i*DW +: DW]));
                eb = PW'($signed(w[i*DW +: DW]));
            end else begin
                ea = PW'(p[i*DW +: DW]);
                eb = PW'(w[i*DW +: DW]);
            end
            prod_in[i] = ea * eb;
        end
    end

    // ------------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------------
    logic           s1_valid, s1_first, s1_last, s1_signed, s1_relu;
    logic [PW-1:0]  s1_prod [LANES];
    logic [BW-1:0]  s1_bias;

    logic           s2_valid, s2_first, s2_last, s2_signed, s2_relu;
    logic [SW-1:0]  s2_sum;
    logic [BW-1:0]  s2_bias;

    logic signed [ACCW-1:0] acc;

    // ------------------------------------------------------------------------
    // S2 adder tree: products are extended to SW with the stage's mode.
    // ------------------------------------------------------------------------
    logic [SW-1:0] tree_sum;

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_signed) begin
                tree_sum = tree_sum + SW'($signed(s1_prod[i]));
            end else begin
                tree_sum = tree_sum + SW'(s1_prod[i]);
            end
        end
    end

    // ------------------------------------------------------------------------
    // S3 accumulate, bias, ReLU and saturation
    // ------------------------------------------------------------------------
    logic signed [ACCW-1:0] sum_ext;
    logic signed [ACCW-1:0] bias_ext;
    logic signed [ACCW-1:0] acc_next;
    logic signed [ACCW-1:0] total;
    logic signed [EW-1:0]   ext;
    logic [OUTW-1:0]        res;
    logic                   res_sat;

    always_comb begin
        if (s2_signed) begin
            sum_ext  = ACCW'($signed(s2_sum));
            bias_ext = ACCW'($signed(s2_bias));
        end else begin
            sum_ext  = ACCW'(s2_sum);
            bias_ext = ACCW'(s2_bias);
        end

        acc_next = s2_first ? sum_ext : acc + sum_ext;
        total    = acc_next + bias_ext;
        ext      = EW'(total);

        if (s2_relu && s2_signed && (ext < 0)) begin
            ext = '0;
        end

        res     = OUTW'(ext);
        res_sat = 1'b0;
        if (s2_signed) begin
            if (ext > SMAX) begin
                res     = OUTW'(SMAX);
                res_sat = 1'b1;
            end else if (ext < SMIN) begin
                res     = OUTW'(SMIN);
                res_sat = 1'b1;
            end
        end else if (ext > UMAX) begin
            res     = OUTW'(UMAX);
            res_sat = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Control path: valid/tag bits, accumulator and output register.
    // clear takes priority over everything except reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_signed <= 1'b0;
            s1_relu   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            s2_signed <= 1'b0;
            s2_relu   <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
            out_sat   <= 1'b0;
        end else if (clear) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_first  <= beat_first;
                s1_last   <= beat_last;
                s1_signed <= eff_signed;
                s1_relu   <= eff_relu;
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_first  <= s1_first;
                s2_last   <= s1_last;
                s2_signed <= s1_signed;
                s2_relu   <= s1_relu;
            end

            if (s2_valid) begin
                acc <= acc_next;
            end

            // Not stalled means any held result is being consumed now, so
            // out_valid simply follows whether a new result is landing.
            out_valid <= s2_valid & s2_last;
            if (s2_valid && s2_last) begin
                dout    <= res;
                out_sat <= res_sat;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Data path registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: datapath registers have no reset; the valid/tag bits qualify
        // them, so their power-up contents are never observed.
        if (accept) begin
            s1_prod <= prod_in;
            s1_bias <= eff_bias;
            if (beat_first) begin
                cur_signed <= mode_signed;
                cur_relu   <= relu_en;
                cur_bias   <= bias;
            end
        end
        if (!stall && s1_valid) begin
            s2_sum  <= tree_sum;
            s2_bias <= s1_bias;
        end
    end

endmodule

// File: tb/tb_mac_acc_pipe.sv
// ============================================================================
// tb_mac_acc_pipe
// ----------------------------------------------------------------------------
// Scoreboard bench for mac_acc_pipe. Two instances share every input: the
// default OUTW=22 build and an OUTW=16 build that exercises saturation.
// The stimulus side pushes hand-computed expectations for both instances;
// a monitor pops and compares whenever a result is consumed.
// ============================================================================
module tb_mac_acc_pipe;

    localparam int LANES  = 16;
    localparam int DW     = 8;
    localparam int BW     = 8;
    localparam int BEATS  = 4;
    localparam int OUTW   = 22;
    localparam int OUTW_N = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clear;
    logic                 mode_signed;
    logic                 relu_en;
    logic                 in_valid;
    logic                 out_ready;
    logic [LANES*DW-1:0]  p;
    logic [LANES*DW-1:0]  w;
    logic [BW-1:0]        bias;

    logic                 in_ready, out_valid, out_sat;
    logic [OUTW-1:0]      dout;
    logic                 in_ready_n, out_valid_n, out_sat_n;
    logic [OUTW_N-1:0]    dout_n;

    always #5 clk = ~clk;

    mac_acc_pipe #(
        .LANES(LANES), .DW(DW), .BW(BW), .BEATS(BEATS), .OUTW(OUTW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode_signed(mode_signed),
        .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready),
        .p(p), .w(w), .bias(bias), .out_valid(out_valid),
        .out_ready(out_ready), .dout(dout), .out_sat(out_sat)
    );

    mac_acc_pipe #(
        .LANES(LANES), .DW(DW), .BW(BW), .BEATS(BEATS), .OUTW(OUTW_N)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode_signed(mode_signed),
        .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready_n),
        .p(p), .w(w), .bias(bias), .out_valid(out_valid_n),
        .out_ready(out_ready), .dout(dout_n), .out_sat(out_sat_n)
    );

    typedef struct {
        string        name;
        logic [21:0]  d;
        logic         s;
        logic [15:0]  dn;
        logic         sn;
    } exp_t;

    exp_t    sb[$];
    int      n_pass  = 0;
    int      n_total = 0;
    longint  cycle   = 0;
    longint  pop_cycles[$];

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endtask

    function automatic logic [LANES*DW-1:0] fill(input logic [DW-1:0] v);
        logic [LANES*DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    // Present one beat and wait (bounded) until it is accepted; returns at
    // posedge+1 of the accepting edge so the next beat can follow directly.
    task automatic send_beat(input logic [LANES*DW-1:0] pv, input logic [LANES*DW-1:0] wv,
                             input logic [BW-1:0] bv, input logic ms, input logic re);
        bit done;
        done        = 1'b0;
        p           = pv;
        w           = wv;
        bias        = bv;
        mode_signed = ms;
        relu_en     = re;
        in_valid    = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) check(1'b0, "beat_accept_timeout", 64'd0, 64'd1);
    endtask

    // Full neuron with the same byte in every lane. With scramble set, the
    // later beats carry inverted mode/relu and a different bias, which must
    // all be ignored.
    task automatic send_uniform(input string nm, input logic [7:0] pv, input logic [7:0] wv,
                                input logic [7:0] bv, input logic ms, input logic re,
                                input bit scramble, input logic [21:0] d, input logic s,
                                input logic [15:0] dn, input logic sn);
        exp_t e;
        e.name = nm; e.d = d; e.s = s; e.dn = dn; e.sn = sn;
        sb.push_back(e);
        for (int b = 0; b < BEATS; b++) begin
            if (b == 0 || !scramble) send_beat(fill(pv), fill(wv), bv, ms, re);
            else send_beat(fill(pv), fill(wv), bv ^ 8'hA5, ~ms, ~re);
        end
    endtask

    always @(posedge clk) cycle++;

    // Monitor: compare on every consumed result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_output", 64'(dout), 64'd0);
            end else begin
                e = sb.pop_front();
                check(dout === e.d, {e.name, "_dout"}, 64'(dout), 64'(e.d));
                check(out_sat === e.s, {e.name, "_sat"}, 64'(out_sat), 64'(e.s));
                check(out_valid_n === 1'b1, {e.name, "_n_valid"}, 64'(out_valid_n), 64'd1);
                check(dout_n === e.dn, {e.name, "_n_dout"}, 64'(dout_n), 64'(e.dn));
                check(out_sat_n === e.sn, {e.name, "_n_sat"}, 64'(out_sat_n), 64'(e.sn));
            end
            pop_cycles.push_back(cycle);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [LANES*DW-1:0] ramp;
        exp_t                e;
        bit                  seen;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        p = '0; w = '0; bias = '0; mode_signed = 1'b0; relu_en = 1'b0;
        #2;
        check(out_valid === 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
        check(dout === '0, "rst_dout", 64'(dout), 64'd0);
        check(out_sat === 1'b0, "rst_out_sat", 64'(out_sat), 64'd0);
        check(in_ready === 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);
        check(out_valid_n === 1'b0, "rst_n_out_valid", 64'(out_valid_n), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic unsigned neuron with latency check: 16*4*1 + 11 = 75.
        send_uniform("t1", 8'h01, 8'h01, 8'd11, 1'b0, 1'b0, 1'b0, 22'h4B, 1'b0, 16'h4B, 1'b0);
        check(out_valid === 1'b0, "t1_lat_edge0", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check(out_valid === 1'b0, "t1_lat_edge1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check(out_valid === 1'b1, "t1_lat_edge2", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Unsigned worst case: 64*65025 + 255 = 4161855; clamps at OUTW=16.
        send_uniform("t2", 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 22'h3F813F, 1'b0, 16'hFFFF, 1'b1);
        // Signed 1*-1 over 64 pairs = -64; mode/relu/bias taken from beat 0.
        send_uniform("t3_signed", 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 22'h3FFFC0, 1'b0, 16'hFFC0, 1'b0);
        send_uniform("t3_relu", 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b1, 22'h000000, 1'b0, 16'h0000, 1'b0);
        // Signed -128*127*64 = -1040384; clamps to -32768 at OUTW=16.
        send_uniform("neg_sat", 8'h80, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 22'h302000, 1'b0, 16'h8000, 1'b1);
        // Signed -128*-128*64 + 127 = 1048703; ReLU leaves positives alone.
        send_uniform("pos_sat", 8'h80, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, 22'h10007F, 1'b0, 16'h7FFF, 1'b1);

        // Lane ramp p[i]=i, weight = beat+1: 120 * (1+2+3+4) = 1200.
        for (int i = 0; i < LANES; i++) ramp[i*DW +: DW] = DW'(i);
        e.name = "ramp"; e.d = 22'h4B0; e.s = 1'b0; e.dn = 16'h4B0; e.sn = 1'b0;
        sb.push_back(e);
        for (int b = 0; b < BEATS; b++) send_beat(ramp, fill(8'(b + 1)), 8'h00, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check(sb.size() == 0, "directed_drain", 64'(sb.size()), 64'd0);

        // Backpressure: three neurons while the first result is held.
        out_ready = 1'b0;
        fork
            begin
                send_uniform("bp1", 8'h01, 8'h01, 8'd11, 1'b0, 1'b0, 1'b0, 22'h4B, 1'b0, 16'h4B, 1'b0);
                send_uniform("bp2", 8'h02, 8'h03, 8'd5, 1'b0, 1'b0, 1'b0, 22'h185, 1'b0, 16'h185, 1'b0);
                send_uniform("bp3", 8'h80, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, 22'h10007F, 1'b0, 16'h7FFF, 1'b1);
            end
            begin
                repeat (12) @(posedge clk);
                #1;
                check(in_ready === 1'b0, "bp_in_ready_low", 64'(in_ready), 64'd0);
                check(out_valid === 1'b1, "bp_held_valid", 64'(out_valid), 64'd1);
                check(dout === 22'h4B, "bp_held_dout", 64'(dout), 64'h4B);
                repeat (3) @(posedge clk);
                #1;
                check(dout === 22'h4B, "bp_stable_dout", 64'(dout), 64'h4B);
                check(out_valid === 1'b1, "bp_stable_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check(sb.size() == 0, "bp_drain", 64'(sb.size()), 64'd0);

        // Throughput: back-to-back neurons, one result every BEATS cycles.
        pop_cycles.delete();
        for (int n = 0; n < 3; n++)
            send_uniform("tp", 8'h01, 8'h01, 8'd11, 1'b0, 1'b0, 1'b0, 22'h4B, 1'b0, 16'h4B, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check(pop_cycles.size() == 3, "tp_count", 64'(pop_cycles.size()), 64'd3);
        if (pop_cycles.size() >= 3) begin
            check(pop_cycles[1] - pop_cycles[0] == BEATS, "tp_gap1",
                  64'(pop_cycles[1] - pop_cycles[0]), 64'(BEATS));
            check(pop_cycles[2] - pop_cycles[1] == BEATS, "tp_gap2",
                  64'(pop_cycles[2] - pop_cycles[1]), 64'(BEATS));
        end

        // clear after two beats, then clear together with a presented beat.
        send_beat(fill(8'hFF), fill(8'hFF), 8'hFF, 1'b0, 1'b0);
        send_beat(fill(8'hFF), fill(8'hFF), 8'hFF, 1'b0, 1'b0);
        clear = 1'b1; in_valid = 1'b1; p = fill(8'h33); w = fill(8'h33); bias = 8'h44;
        @(negedge clk);
        check(in_ready === 1'b0, "clr_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        send_uniform("clr_next", 8'h01, 8'h01, 8'd11, 1'b0, 1'b0, 1'b0, 22'h4B, 1'b0, 16'h4B, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check(sb.size() == 0, "clr_drain", 64'(sb.size()), 64'd0);

        // Asynchronous reset mid-neuron; dout still holds 0x4B beforehand.
        send_beat(fill(8'hFF), fill(8'hFF), 8'hFF, 1'b0, 1'b0);
        send_beat(fill(8'hFF), fill(8'hFF), 8'hFF, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check(out_valid === 1'b0, "rst1_out_valid", 64'(out_valid), 64'd0);
        check(dout === '0, "rst1_dout", 64'(dout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_uniform("rst1_next", 8'h01, 8'h01, 8'd11, 1'b0, 1'b0, 1'b0, 22'h4B, 1'b0, 16'h4B, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check(sb.size() == 0, "rst1_drain", 64'(sb.size()), 64'd0);

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        send_uniform("rst2_held", 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 22'h3F813F, 1'b0, 16'hFFFF, 1'b1);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(posedge clk); #1;
            seen = out_valid;
        end
        check(out_valid === 1'b1, "rst2_held_valid", 64'(out_valid), 64'd1);
        check(out_sat_n === 1'b1, "rst2_held_sat_n", 64'(out_sat_n), 64'd1);
        sb.delete();
        #2 rst_n = 1'b0;
        #1;
        check(out_valid === 1'b0, "rst2_out_valid", 64'(out_valid), 64'd0);
        check(dout === '0, "rst2_dout", 64'(dout), 64'd0);
        check(out_sat_n === 1'b0, "rst2_out_sat_n", 64'(out_sat_n), 64'd0);
        check(in_ready === 1'b1, "rst2_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_uniform("rst2_next", 8'h01, 8'h01, 8'd11, 1'b0, 1'b0, 1'b0, 22'h4B, 1'b0, 16'h4B, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check(sb.size() == 0, "final_drain", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
